// File: rtl/os_skew_feeder.sv
// os_skew_feeder: input skew stage for the output-stationary FP systolic array.
// Accepts one K-step beat (N row operands, N column operands) per handshake and
// delays lane i by i extra cycles so operands meet diagonally in the PE grid.
// Per-lane valid / accumulator-clear / last flags travel with the data, and a
// one-cycle done pulse marks the final beat leaving lane N-1.
//
// Build option: FEEDER_ZERO_BUBBLE_EN
//   defined   - stages carrying no operand hold zero data
//   undefined - bubble stages carry whatever in_a/in_b held (don't-care data)
module os_skew_feeder #(
    parameter int N      = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic [N*DATA_W-1:0]   in_b,
    output logic [N*DATA_W-1:0]   a_skew,
    output logic [N*DATA_W-1:0]   b_skew,
    output logic [N-1:0]          lane_vld,
    output logic [N-1:0]          lane_clr,
    output logic [N-1:0]          lane_last,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W-1:0]      beat_cnt,
    output logic                  cnt_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Drain counter counts N-1 down to 0, so DRAIN lasts exactly N cycles.
    localparam int                DRN_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DRN_W-1:0]   r_drain;
    logic [DRN_W-1:0]   w_drain_nxt;
    logic               r_done;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_cnt_ovf;

    logic               w_ready;
    logic               w_accept;
    logic               w_first;

    assign w_ready  = (r_state != ST_DRAIN);
    assign w_accept = in_valid && w_ready;
    // First accepted beat out of IDLE opens a new tile.
    assign w_first  = w_accept && (r_state == ST_IDLE);

    // Next-state and drain-counter logic for the tile sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_last) begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = DRN_LOAD;
                    end else begin
                        w_state_nxt = ST_STREAM;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_accept && in_last) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DRN_LOAD;
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (r_drain != '0) begin
                    w_drain_nxt = r_drain - DRN_W'(1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_drain_nxt = '0;
            end
        endcase
    end

    // State register, drain counter and registered done pulse; done rises for
    // the final DRAIN cycle, when the last beat sits in lane N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_done  <= (w_state_nxt == ST_DRAIN) && (w_drain_nxt == '0);
        end
    end

    // Beat counter: restarts at 1 on a new tile, saturates, and flags an accept
    // that arrives once the count can no longer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_cnt_ovf  <= 1'b0;
        end else if (w_first) begin
            r_beat_cnt <= CNT_ONE;
            r_cnt_ovf  <= 1'b0;
        end else if (w_accept) begin
            if (r_beat_cnt == CNT_MAX) begin
                r_cnt_ovf  <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + CNT_ONE;
            end
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end

    // Skew chains: lane i holds i+1 stages and shifts every cycle, since the
    // array downstream never stalls.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] r_a    [0:i];
        logic [DATA_W-1:0] r_b    [0:i];
        logic [i:0]        r_vld;
        logic [i:0]        r_clr;
        logic [i:0]        r_last;
        logic [DATA_W-1:0] w_a_in;
        logic [DATA_W-1:0] w_b_in;

`ifdef FEEDER_ZERO_BUBBLE_EN
        assign w_a_in = w_accept ? in_a[i*DATA_W +: DATA_W] : '0;
        assign w_b_in = w_accept ? in_b[i*DATA_W +: DATA_W] : '0;
`else
        assign w_a_in = in_a[i*DATA_W +: DATA_W];
        assign w_b_in = in_b[i*DATA_W +: DATA_W];
`endif

        // Stage 0 samples the input beat (or a bubble); later stages shift.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                end
                r_vld  <= '0;
                r_clr  <= '0;
                r_last <= '0;
            end else begin
                r_a[0]    <= w_a_in;
                r_b[0]    <= w_b_in;
                r_vld[0]  <= w_accept;
                r_clr[0]  <= w_first;
                r_last[0] <= w_accept && in_last;
                for (int k = 1; k <= i; k++) begin
                    r_a[k]    <= r_a[k-1];
                    r_b[k]    <= r_b[k-1];
                    r_vld[k]  <= r_vld[k-1];
                    r_clr[k]  <= r_clr[k-1];
                    r_last[k] <= r_last[k-1];
                end
            end
        end

        assign a_skew[i*DATA_W +: DATA_W] = r_a[i];
        assign b_skew[i*DATA_W +: DATA_W] = r_b[i];
        assign lane_vld[i]  = r_vld[i];
        assign lane_clr[i]  = r_clr[i];
        assign lane_last[i] = r_last[i];
    end

    assign in_ready = w_ready;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign beat_cnt = r_beat_cnt;
    assign cnt_ovf  = r_cnt_ovf;

endmodule

// File: doc/os_skew_feeder.md
# os_skew_feeder

Input skew stage for the output-stationary floating-point systolic array. Accepts one K-step of operands per beat (N values of A for the array rows, N values of B for the array columns) over a valid/ready handshake. Re-times lane i by i extra cycles so operands meet diagonally in the PE grid. Emits per-lane valid, accumulator-clear and last flags, plus a tile-done pulse once the final beat has reached lane N-1.

## Interface
- N, 16, array dimension (lanes per operand side), ≥1
- DATA_W, 32, operand width (IEEE-754 single, passed through untouched)
- CNT_W, 16, width of the beat counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat can be accepted
- in_last  in  1  beat is the final K-step of the tile
- in_a  in  N*DATA_W  row operands, lane i at bits [i*DATA_W +: DATA_W]
- in_b  in  N*DATA_W  column operands, same packing
- a_skew  out  N*DATA_W  skewed row operands to array west edge
- b_skew  out  N*DATA_W  skewed column operands to array north edge
- lane_vld  out  N  lane i carries a real operand this cycle
- lane_clr  out  N  lane i carries the first beat of a tile (PE overwrites accumulator)
- lane_last  out  N  lane i carries the last beat of a tile
- done  out  1  one-cycle pulse: tile fully injected
- busy  out  1  state ≠ IDLE
- beat_cnt  out  CNT_W  beats accepted in the current or most recent tile
- cnt_ovf  out  1  sticky: beat_cnt saturated this tile

## Operation
- Handshake: a beat is accepted when in_valid && in_ready. in_ready = (state != DRAIN).
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: on accept with in_last=0 → STREAM; with in_last=1 → DRAIN.
  - STREAM: on accept with in_last=1 → DRAIN. Otherwise stay.
  - DRAIN: stay while the drain counter is nonzero, then → IDLE.
- Bubbles: no accept in STREAM injects a bubble. The lane-0 stage loads with vld=0, clr=0, last=0. The array has no backpressure, so the skew chain shifts every cycle unconditionally.
- Skew: lane i is a chain of i+1 registers. Each stage holds {a, b, vld, clr, last}.
- Flag sourcing:
  - clr is set on the first accepted beat after IDLE.
  - last is set from in_last.
- beat_cnt:
  - Loads 1 on the first accept out of IDLE.
  - +1 per further accept, saturating at 2^CNT_W−1.
  - Saturation sets cnt_ovf.
  - Both hold their values through IDLE. Both clear when the next tile starts.
- A single-beat tile (in_last on first accept) has clr and last both high on that beat.

## Timing
- Beat accepted at cycle t appears on lane i of a_skew/b_skew/flags at cycle t+1+i.
- After the last beat is accepted at t:
  - DRAIN occupies cycles t+1 … t+N, with in_ready=0.
  - done pulses at t+N, coincident with lane_vld[N-1] && lane_last[N-1].
  - State is IDLE and in_ready=1 at t+N+1.
- busy goes high the cycle after the first accept and low at t+N+1.
- Back-to-back beats in STREAM: one per cycle, no gaps required.
- Reset values (synchronous, next edge with rst=1):
  - state=IDLE, in_ready=1.
  - All skew stages zero: a_skew=0, b_skew=0, lane_vld=0, lane_clr=0, lane_last=0.
  - done=0, busy=0, beat_cnt=0, cnt_ovf=0.
- Reset mid-tile aborts it: in-flight beats are discarded and no done is issued.
- in_valid while in DRAIN is ignored (not accepted). Input data need not be held stable beyond the accept edge.

## Configuration
- FEEDER_ZERO_BUBBLE_EN
  - Defined: any stage whose vld=0 forces its a/b data to 0. a_skew/b_skew lanes read 0 whenever the corresponding lane_vld is 0. This gives clean waveforms and lets gated PEs skip the FP multiply.
  - Undefined: bubble stages load in_a/in_b unconditionally. Data on invalid lanes is don't-care, which saves the data-path muxes. The flag behaviour is identical in both builds.

## Test plan
- N=16, reset, then 4 back-to-back beats with in_a lane i = 0x3F800000+i, last on beat 4 (accepts at cycles 0–3):
  - Lane 5 shows beat 1 at cycle 6 with clr=1, and beat 4 at cycle 9 with last=1.
  - done at cycle 19; in_ready=0 during cycles 4–19; beat_cnt=4.
- Single-beat tile (in_valid=in_last=1 at cycle 0):
  - Every lane i shows clr=1 and last=1 at cycle 1+i.
  - done at cycle 16; in_ready high again at cycle 17.
- Bubble: beats at cycles 0 and 2, in_valid low at cycle 1, last at cycle 2:
  - lane_vld[3] is 1, 0, 1 at cycles 4, 5, 6.
  - With FEEDER_ZERO_BUBBLE_EN defined, a_skew lane 3 = 0 at cycle 5.
- in_valid held high during DRAIN with distinct data: no accept, beat_cnt unchanged. The next tile starts at cycle t+N+1 with clr=1.
- rst asserted at cycle 8 of a 10-beat tile:
  - Next cycle all lane_vld=0, busy=0, in_ready=1, beat_cnt=0.
  - No done pulse follows.
- CNT_W=4, 17 beats: beat_cnt saturates at 15 and cnt_ovf=1. Both clear on the first accept of the next tile.
